// File: rtl/mvm_pkg.sv
// Shared types and default widths for the MVM command scheduler.
package mvm_pkg;

   localparam int MVM_VEC_ADDRW     = 8;
   localparam int MVM_MAT_ADDRW     = 9;
   localparam int MVM_VEC_SIZEW     = MVM_VEC_ADDRW + 1;
   localparam int MVM_MAT_SIZEW     = MVM_MAT_ADDRW + 1;
   localparam int MVM_TAG_W         = 4;
   localparam int MVM_FIFO_DEPTH    = 4;
   localparam int MVM_DRAIN_CYCLES  = 6;

   typedef struct packed {
      logic [MVM_VEC_ADDRW-1:0] vec_start_addr;
      logic [MVM_VEC_SIZEW-1:0] vec_num_words;
      logic [MVM_MAT_ADDRW-1:0] mat_start_addr;
      logic [MVM_MAT_SIZEW-1:0] mat_rows;
      logic [MVM_TAG_W-1:0]     tag;
   } mvm_cmd_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_RUN,
      S_DRAIN,
      S_DONE,
      S_REJECT
   } sched_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO over a generic payload type; rdata is the head entry.
module sync_fifo #(
   parameter type T     = logic [7:0],
   parameter int  DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  T                         wdata,
   input  logic                     pop,
   output T                         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

   T                 mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // NOTE: storage is deliberately left out of reset; only pointers and count
   // define validity, so clearing the array would just cost reset fan-out.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mvm_cmd_sched.sv
// Queues host MVM commands and issues them one at a time to the control FSM,
// reporting each completion (or zero-length rejection) with its tag.
module mvm_cmd_sched
   import mvm_pkg::*;
#(
   parameter int VEC_ADDRW    = MVM_VEC_ADDRW,
   parameter int MAT_ADDRW    = MVM_MAT_ADDRW,
   parameter int VEC_SIZEW    = VEC_ADDRW + 1,
   parameter int MAT_SIZEW    = MAT_ADDRW + 1,
   parameter int TAG_W        = MVM_TAG_W,
   parameter int FIFO_DEPTH   = MVM_FIFO_DEPTH,
   parameter int DRAIN_CYCLES = MVM_DRAIN_CYCLES
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic [VEC_ADDRW-1:0]            cmd_vec_start_addr,
   input  logic [VEC_SIZEW-1:0]            cmd_vec_num_words,
   input  logic [MAT_ADDRW-1:0]            cmd_mat_start_addr,
   input  logic [MAT_SIZEW-1:0]            cmd_mat_rows,
   input  logic [TAG_W-1:0]                cmd_tag,
   output logic                            start,
   output logic [VEC_ADDRW-1:0]            vec_start_addr,
   output logic [VEC_SIZEW-1:0]            vec_num_words,
   output logic [MAT_ADDRW-1:0]            mat_start_addr,
   output logic [MAT_SIZEW-1:0]            mat_num_rows_per_olane,
   input  logic                            ctrl_busy,
   output logic                            done_valid,
   output logic [TAG_W-1:0]                done_tag,
   output logic                            done_err,
   output logic [$clog2(FIFO_DEPTH):0]     pending,
   output logic                            idle
);

   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

   // Local copy of the command layout so non-default widths still line up.
   typedef struct packed {
      logic [VEC_ADDRW-1:0] vec_start_addr;
      logic [VEC_SIZEW-1:0] vec_num_words;
      logic [MAT_ADDRW-1:0] mat_start_addr;
      logic [MAT_SIZEW-1:0] mat_rows;
      logic [TAG_W-1:0]     tag;
   } cmd_t;

   cmd_t               wr_cmd;
   cmd_t               head;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic               push;
   logic               pop;
   logic               head_zero;
   sched_state_e       state;
   logic [DRAIN_W-1:0] drain_cnt;
   logic [TAG_W-1:0]   cur_tag;

   assign wr_cmd = '{vec_start_addr: cmd_vec_start_addr,
                     vec_num_words:  cmd_vec_num_words,
                     mat_start_addr: cmd_mat_start_addr,
                     mat_rows:       cmd_mat_rows,
                     tag:            cmd_tag};

   // Full means refuse, even if the FSM pops the head in the same cycle.
   assign cmd_ready = !fifo_full && !rst;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == S_IDLE) && !fifo_empty;
   assign head_zero = (head.vec_num_words == '0) || (head.mat_rows == '0);

   assign pending = fifo_count + CNT_W'(state != S_IDLE);
   assign idle    = fifo_empty && (state == S_IDLE);

   sync_fifo #(
      .T     (cmd_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (wr_cmd),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state                  <= S_IDLE;
         drain_cnt              <= '0;
         cur_tag                <= '0;
         start                  <= 1'b0;
         vec_start_addr         <= '0;
         vec_num_words          <= '0;
         mat_start_addr         <= '0;
         mat_num_rows_per_olane <= '0;
         done_valid             <= 1'b0;
         done_tag               <= '0;
         done_err               <= 1'b0;
      end else begin
         start      <= 1'b0;
         done_valid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  cur_tag <= head.tag;
                  if (head_zero) begin
                     state      <= S_REJECT;
                     done_valid <= 1'b1;
                     done_tag   <= head.tag;
                     done_err   <= 1'b1;
                  end else begin
                     state                  <= S_ISSUE;
                     start                  <= 1'b1;
                     vec_start_addr         <= head.vec_start_addr;
                     vec_num_words          <= head.vec_num_words;
                     mat_start_addr         <= head.mat_start_addr;
                     mat_num_rows_per_olane <= head.mat_rows;
                  end
               end
            end
            S_ISSUE:     state <= S_WAIT_BUSY;
            S_WAIT_BUSY: if (ctrl_busy) state <= S_RUN;
            S_RUN: begin
               if (!ctrl_busy) begin
                  state     <= S_DRAIN;
                  drain_cnt <= DRAIN_LOAD;
               end
            end
            S_DRAIN: begin
               // Results are committed DRAIN_CYCLES after busy falls.
               if (drain_cnt == '0) begin
                  state      <= S_DONE;
                  done_valid <= 1'b1;
                  done_tag   <= cur_tag;
                  done_err   <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            S_DONE, S_REJECT: state <= S_IDLE;
            default:          state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mvm_cmd_sched.sv
// Scoreboard bench for mvm_cmd_sched with a behavioural control-FSM model.
module tb_mvm_cmd_sched;
   import mvm_pkg::*;

   localparam int DRAIN = MVM_DRAIN_CYCLES;
   localparam int PW    = $clog2(MVM_FIFO_DEPTH) + 1;

   logic                     clk;
   logic                     rst;
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [MVM_VEC_ADDRW-1:0] cmd_vec_start_addr;
   logic [MVM_VEC_SIZEW-1:0] cmd_vec_num_words;
   logic [MVM_MAT_ADDRW-1:0] cmd_mat_start_addr;
   logic [MVM_MAT_SIZEW-1:0] cmd_mat_rows;
   logic [MVM_TAG_W-1:0]     cmd_tag;
   logic                     start;
   logic [MVM_VEC_ADDRW-1:0] vec_start_addr;
   logic [MVM_VEC_SIZEW-1:0] vec_num_words;
   logic [MVM_MAT_ADDRW-1:0] mat_start_addr;
   logic [MVM_MAT_SIZEW-1:0] mat_num_rows_per_olane;
   logic                     ctrl_busy;
   logic                     done_valid;
   logic [MVM_TAG_W-1:0]     done_tag;
   logic                     done_err;
   logic [PW-1:0]            pending;
   logic                     idle;

   mvm_cmd_sched #(
      .VEC_ADDRW    (MVM_VEC_ADDRW),
      .MAT_ADDRW    (MVM_MAT_ADDRW),
      .VEC_SIZEW    (MVM_VEC_SIZEW),
      .MAT_SIZEW    (MVM_MAT_SIZEW),
      .TAG_W        (MVM_TAG_W),
      .FIFO_DEPTH   (MVM_FIFO_DEPTH),
      .DRAIN_CYCLES (MVM_DRAIN_CYCLES)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .cmd_valid              (cmd_valid),
      .cmd_ready              (cmd_ready),
      .cmd_vec_start_addr     (cmd_vec_start_addr),
      .cmd_vec_num_words      (cmd_vec_num_words),
      .cmd_mat_start_addr     (cmd_mat_start_addr),
      .cmd_mat_rows           (cmd_mat_rows),
      .cmd_tag                (cmd_tag),
      .start                  (start),
      .vec_start_addr         (vec_start_addr),
      .vec_num_words          (vec_num_words),
      .mat_start_addr         (mat_start_addr),
      .mat_num_rows_per_olane (mat_num_rows_per_olane),
      .ctrl_busy              (ctrl_busy),
      .done_valid             (done_valid),
      .done_tag               (done_tag),
      .done_err               (done_err),
      .pending                (pending),
      .idle                   (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      mvm_cmd_t cmd;
      int       acc_cyc;
      bit       was_idle;
   } exp_t;

   int       checks   = 0;
   int       failures = 0;
   int       cyc      = 0;
   int       exp_pending = 0;
   exp_t     done_q[$];
   exp_t     start_q[$];
   bit       hold_busy = 1'b0;
   int       busy_len  = 8;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] cfg_bits(input mvm_cmd_t c);
      return 64'({c.vec_start_addr, c.vec_num_words, c.mat_start_addr, c.mat_rows});
   endfunction

   function automatic mvm_cmd_t make_cmd(input int va, input int nw, input int ma,
                                         input int rows, input int tag);
      mvm_cmd_t c;
      c.vec_start_addr = MVM_VEC_ADDRW'(va);
      c.vec_num_words  = MVM_VEC_SIZEW'(nw);
      c.mat_start_addr = MVM_MAT_ADDRW'(ma);
      c.mat_rows       = MVM_MAT_SIZEW'(rows);
      c.tag            = MVM_TAG_W'(tag);
      return c;
   endfunction

   function automatic mvm_cmd_t rand_cmd(input int tag, input bit allow_zero);
      int nw   = $urandom_range(1, 256);
      int rows = $urandom_range(1, 512);
      if (allow_zero && $urandom_range(0, 7) == 0) nw = 0;
      if (allow_zero && $urandom_range(0, 7) == 0) rows = 0;
      return make_cmd($urandom_range(0, 255), nw, $urandom_range(0, 511), rows, tag);
   endfunction

   // Monitor, scoreboard and control-FSM model, all evaluated mid-cycle.
   initial begin
      logic [63:0] cfg_now;
      logic [63:0] cur_cfg = '0;
      logic        prev_start = 1'b0;
      int          ctl_wait = 0;
      int          ctl_left = 0;
      int          fall_cyc = -1000;
      exp_t        e;
      ctrl_busy = 1'b0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         cyc++;
         check("pending", 64'(pending), 64'(exp_pending));
         check("idle", 64'(idle), 64'(exp_pending == 0));
         if (rst) check("ready_in_rst", 64'(cmd_ready), 64'd0);
         cfg_now = 64'({vec_start_addr, vec_num_words, mat_start_addr, mat_num_rows_per_olane});
         if (start) begin
            check("start_one_cycle", 64'(prev_start), 64'd0);
            check("busy_at_start", 64'(ctrl_busy), 64'd0);
            check("start_expected", 64'(start_q.size() > 0), 64'd1);
            if (start_q.size() > 0) begin
               e = start_q.pop_front();
               check("start_cfg", cfg_now, cfg_bits(e.cmd));
               if (e.was_idle) check("start_latency", 64'(cyc - e.acc_cyc), 64'd2);
               cur_cfg = cfg_bits(e.cmd);
            end
         end else begin
            check("cfg_hold", cfg_now, cur_cfg);
         end
         if (done_valid) begin
            check("done_expected", 64'(done_q.size() > 0), 64'd1);
            if (done_q.size() > 0) begin
               logic err;
               e   = done_q.pop_front();
               err = (e.cmd.vec_num_words == 0) || (e.cmd.mat_rows == 0);
               check("done_tag", 64'(done_tag), 64'(e.cmd.tag));
               check("done_err", 64'(done_err), 64'(err));
               if (!err) check("done_after_busy_fall", 64'(cyc - fall_cyc), 64'(DRAIN + 1));
               else if (e.was_idle) check("reject_latency", 64'(cyc - e.acc_cyc), 64'd2);
            end
         end
         // Control-FSM model: busy two cycles after start, for busy_len cycles.
         if (ctl_wait > 0) begin
            ctl_wait--;
            if (ctl_wait == 0) begin
               ctrl_busy = 1'b1;
               ctl_left  = busy_len;
            end
         end else if (ctrl_busy) begin
            if (ctl_left > 0) ctl_left--;
            if (ctl_left == 0 && !hold_busy) begin
               ctrl_busy = 1'b0;
               fall_cyc  = cyc;
            end
         end
         if (start) ctl_wait = 2;
         if (cmd_valid && cmd_ready) begin
            e.cmd = make_cmd(cmd_vec_start_addr, cmd_vec_num_words, cmd_mat_start_addr,
                             cmd_mat_rows, cmd_tag);
            e.acc_cyc  = cyc;
            e.was_idle = (exp_pending == 0);
            done_q.push_back(e);
            if (cmd_vec_num_words != 0 && cmd_mat_rows != 0) start_q.push_back(e);
            exp_pending++;
         end
         if (done_valid) exp_pending--;
         if (rst) begin
            done_q.delete();
            start_q.delete();
            exp_pending = 0;
            cur_cfg     = '0;
            ctrl_busy   = 1'b0;
            ctl_wait    = 0;
            ctl_left    = 0;
         end
         prev_start = start;
      end
   end

   task automatic send(input mvm_cmd_t c);
      logic acc = 1'b0;
      cmd_vec_start_addr = c.vec_start_addr;
      cmd_vec_num_words  = c.vec_num_words;
      cmd_mat_start_addr = c.mat_start_addr;
      cmd_mat_rows       = c.mat_rows;
      cmd_tag            = c.tag;
      cmd_valid          = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      cmd_valid = 1'b0;
      check("send_accepted", 64'(acc), 64'd1);
   endtask

   task automatic wait_idle();
      logic ok = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         @(posedge clk);
         #1;
         if (idle && done_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("drained_to_idle", 64'(ok), 64'd1);
      check("outstanding_done", 64'(done_q.size()), 64'd0);
   endtask

   initial begin
      logic seen;
      rst                = 1'b1;
      cmd_valid          = 1'b0;
      cmd_vec_start_addr = '0;
      cmd_vec_num_words  = '0;
      cmd_mat_start_addr = '0;
      cmd_mat_rows       = '0;
      cmd_tag            = '0;
      repeat (3) @(posedge clk);
      #1;
      check("ready_during_rst", 64'(cmd_ready), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_ready", 64'(cmd_ready), 64'd1);
      check("rst_start", 64'(start), 64'd0);
      check("rst_done_valid", 64'(done_valid), 64'd0);
      check("rst_done_tag", 64'(done_tag), 64'd0);
      check("rst_done_err", 64'(done_err), 64'd0);
      check("rst_pending", 64'(pending), 64'd0);
      check("rst_idle", 64'(idle), 64'd1);
      check("rst_cfg", 64'({vec_start_addr, vec_num_words, mat_start_addr,
                            mat_num_rows_per_olane}), 64'd0);

      // Single command.
      busy_len = 8;
      send(make_cmd('h10, 4, 0, 2, 3));
      wait_idle();
      check("single_idle", 64'(idle), 64'd1);

      // Fill the queue while the control FSM stays busy.
      hold_busy = 1'b1;
      busy_len  = 3;
      for (int t = 0; t < 5; t++) send(rand_cmd(t, 1'b0));
      cmd_tag   = 4'd5;
      cmd_valid = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         check("fill_ready_low", 64'(cmd_ready), 64'd0);
         check("fill_pending", 64'(pending), 64'd5);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      hold_busy = 1'b0;
      wait_idle();

      // Zero-length rejection followed by a normal command.
      send(make_cmd('h20, 0, 'h30, 5, 7));
      send(make_cmd('h21, 3, 'h31, 1, 8));
      wait_idle();

      // Push in the same cycle the FSM pops at occupancy 2.
      hold_busy = 1'b1;
      busy_len  = 2;
      for (int t = 1; t <= 3; t++) send(rand_cmd(t, 1'b0));
      hold_busy = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(posedge clk);
         #1;
         if (done_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("pp_done_seen", 64'(seen), 64'd1);
      @(posedge clk);
      #1;
      cmd_tag            = 4'd4;
      cmd_vec_num_words  = 9'd5;
      cmd_mat_rows       = 10'd6;
      cmd_valid          = 1'b1;
      check("pp_pending_idle", 64'(pending), 64'd2);
      check("pp_ready", 64'(cmd_ready), 64'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("pp_pending_after", 64'(pending), 64'd3);
      wait_idle();

      // Reset while a command is running with two more queued.
      hold_busy = 1'b1;
      busy_len  = 4;
      for (int t = 9; t < 12; t++) send(rand_cmd(t, 1'b0));
      seen = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(posedge clk);
         #1;
         if (ctrl_busy) begin
            seen = 1'b1;
            break;
         end
      end
      check("rst_run_reached", 64'(seen), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      hold_busy = 1'b0;
      check("midrst_start", 64'(start), 64'd0);
      check("midrst_pending", 64'(pending), 64'd0);
      check("midrst_idle", 64'(idle), 64'd1);
      check("midrst_done", 64'(done_valid), 64'd0);
      repeat (20) @(posedge clk);
      #1;
      send(make_cmd('h44, 7, 'h55, 3, 12));
      wait_idle();

      // Randomized traffic, including rejects and queue wrap-around.
      for (int i = 0; i < 40; i++) begin
         busy_len = $urandom_range(1, 10);
         send(rand_cmd($urandom_range(0, 15), 1'b1));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      wait_idle();
      check("start_queue_empty", 64'(start_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mvm_cmd_sched.md
Name: mvm_cmd_sched

Overview:
- Command scheduler in front of the MVM control FSM.
- Accepts MVM commands from the host/sequencer over a valid/ready interface and queues them in a small FIFO.
- Issues each command to the control FSM as a one-cycle start pulse with stable configuration, tracks completion through ctrl_busy, waits a fixed datapath drain, then reports completion with the command's tag.

Parameters:
- VEC_ADDRW, 8, vector buffer address width
- MAT_ADDRW, 9, matrix buffer address width
- VEC_SIZEW, VEC_ADDRW+1, vector word-count width
- MAT_SIZEW, MAT_ADDRW+1, rows-per-output-lane width
- TAG_W, 4, command tag width
- FIFO_DEPTH, 4, command queue depth (power of 2, >=2)
- DRAIN_CYCLES, 6, cycles from ctrl_busy fall until results are committed (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue can accept
- cmd_vec_start_addr  in  VEC_ADDRW  vector start address
- cmd_vec_num_words  in  VEC_SIZEW  vector length in words
- cmd_mat_start_addr  in  MAT_ADDRW  matrix start address
- cmd_mat_rows  in  MAT_SIZEW  rows per output lane
- cmd_tag  in  TAG_W  command identifier
- start  out  1  one-cycle start pulse to control FSM
- vec_start_addr  out  VEC_ADDRW  issued config, stable from ISSUE until the next ISSUE
- vec_num_words  out  VEC_SIZEW  issued config
- mat_start_addr  out  MAT_ADDRW  issued config
- mat_num_rows_per_olane  out  MAT_SIZEW  issued config
- ctrl_busy  in  1  busy from control FSM
- done_valid  out  1  one-cycle completion pulse
- done_tag  out  TAG_W  tag of completed command
- done_err  out  1  command rejected (zero length)
- pending  out  $clog2(FIFO_DEPTH)+1  queued plus in-flight count
- idle  out  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset values: cmd_ready=0 during rst, 1 the cycle after; start=0; config outputs=0; done_valid=0; done_tag=0; done_err=0; pending=0; idle=1. Reset mid-operation empties the FIFO and returns the FSM to IDLE with no done pulse. The control FSM shares the same rst.
- FIFO:
  - Push when cmd_valid&&cmd_ready. cmd_ready=!full; no bypass path when full, even with a same-cycle pop.
  - Pop occurs only in the IDLE->ISSUE/REJECT transition.
  - Simultaneous push and pop on a non-full FIFO keeps occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, WAIT_BUSY, RUN, DRAIN, DONE, REJECT.
  - IDLE: if FIFO non-empty, pop the head. Go to REJECT if vec_num_words==0 or mat_rows==0; otherwise latch the head into the config registers and go to ISSUE.
  - ISSUE: start=1 for exactly this cycle; config already stable this cycle. -> WAIT_BUSY.
  - WAIT_BUSY: wait for ctrl_busy=1 (nominally 2 cycles after start). -> RUN.
  - RUN: wait for ctrl_busy=0. -> DRAIN, with drain counter loaded to DRAIN_CYCLES-1.
  - DRAIN: decrement the counter. At 0 -> DONE.
  - DONE: done_valid=1, done_tag=issued tag, done_err=0. -> IDLE.
  - REJECT: done_valid=1, done_tag=tag, done_err=1; start is never asserted. -> IDLE.
- Back-to-back: minimum gap between start pulses is 1 (DONE) + 1 (IDLE) cycles after drain; start is never asserted while ctrl_busy=1.
- pending = FIFO occupancy + (FSM not in IDLE ? 1 : 0). The cycle after the DONE/REJECT pulse, pending has decremented.
- done_valid has no backpressure; the consumer must always accept.
- Config outputs hold the last issued values after DONE, so the control FSM sees stable inputs while IDLE.

Decomposition:
- Shared package mvm_pkg:
  - mvm_cmd_t struct: vec_start_addr, vec_num_words, mat_start_addr, mat_rows, tag.
  - Scheduler state enum.
  - Default width localparams.
- Sub-module sync_fifo: parameterised over a generic type/width and DEPTH; full/empty/count outputs.

Test Plan:
- Single command: vec_start=0x10, words=4, mat_start=0, rows=2, tag=3; ctrl model busy for 8 cycles → one start pulse one cycle after the IDLE pop; done_valid with tag=3 and err=0 exactly DRAIN_CYCLES+1 cycles after ctrl_busy falls; idle returns to 1.
- Fill queue: push 5 commands with tags 0..4 while busy held → cmd_ready=0 after 4 queued plus 1 in flight; pending=5; completions arrive in order 0..4; no start pulse while busy=1.
- Zero-length: words=0, tag=7 → no start; done_valid with err=1 and tag=7 two cycles after push. A following valid command (tag=8) issues normally.
- Simultaneous push/pop: push on the same cycle the FSM pops at occupancy 2 → occupancy stays 2; FIFO pointers wrap correctly over 10 commands.
- Reset mid-RUN with 2 commands queued → start=0, pending=0, idle=1 the next cycle; no done pulse; a subsequent command completes normally.
